// File: rtl/req_ack_fifo_if.sv
// Handshake bundle for req_ack_fifo: upstream req/ack, downstream req/ack.
// Stats signals exist only when REQ_ACK_FIFO_STATS_EN is defined.
interface req_ack_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);
    logic                  up_req;
    logic                  up_ack;
    logic [DATA_WIDTH-1:0] up_din;
    logic                  dn_req;
    logic                  dn_ack;
    logic [DATA_WIDTH-1:0] dn_dout;
    logic [ADDR_WIDTH:0]   occupancy;
`ifdef REQ_ACK_FIFO_STATS_EN
    logic [ADDR_WIDTH:0]   max_occ;
    logic [31:0]           starve_cnt;
`endif

    // FIFO side
    modport slave (
        output up_req,
        input  up_ack,
        input  up_din,
        input  dn_req,
        output dn_ack,
        output dn_dout,
`ifdef REQ_ACK_FIFO_STATS_EN
        output max_occ,
        output starve_cnt,
`endif
        output occupancy
    );

    // Producer/consumer side
    modport master (
        input  up_req,
        output up_ack,
        output up_din,
        output dn_req,
        input  dn_ack,
        input  dn_dout,
`ifdef REQ_ACK_FIFO_STATS_EN
        input  max_occ,
        input  starve_cnt,
`endif
        input  occupancy
    );
endinterface

// File: rtl/req_ack_fifo.sv
// Elastic req/ack buffer between a stream producer and consumer.
// Optional REQ_ACK_FIFO_STATS_EN adds max_occ and starve_cnt outputs.
module req_ack_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input logic            clk,
    input logic            rst,
    req_ack_fifo_if.slave  bus
);
    localparam int OW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [OW-1:0]         r_occ;
    logic                  r_up_req;
    logic                  r_dn_ack;
    logic [DATA_WIDTH-1:0] r_dn_dout;

    logic                  w_push;
    logic                  w_pop;
    logic [OW-1:0]         w_occ_next;
    logic                  w_up_req_next;

    // An ack without a request outstanding is a protocol violation; drop it.
    assign w_push = bus.up_ack && r_up_req && (r_occ < OW'(DEPTH));
    assign w_pop  = bus.dn_req && !r_dn_ack && (r_occ != '0);

    assign w_occ_next = r_occ + OW'(w_push) - OW'(w_pop);

    // Request drops after every ack so each assertion gets at most one word.
    assign w_up_req_next = !bus.up_ack && (w_occ_next < OW'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= bus.up_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_up_req  <= 1'b0;
            r_dn_ack  <= 1'b0;
            r_dn_dout <= '0;
        end else begin
            r_occ    <= w_occ_next;
            r_up_req <= w_up_req_next;
            r_dn_ack <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + ADDR_WIDTH'(1);
                r_dn_dout <= r_mem[r_rptr];
            end
        end
    end

    assign bus.up_req    = r_up_req;
    assign bus.dn_ack    = r_dn_ack;
    assign bus.dn_dout   = r_dn_dout;
    assign bus.occupancy = r_occ;

`ifdef REQ_ACK_FIFO_STATS_EN
    logic [OW-1:0] r_max_occ;
    logic [31:0]   r_starve_cnt;
    logic          w_starve;

    assign w_starve = bus.dn_req && !r_dn_ack && (r_occ == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_occ    <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_occ_next > r_max_occ) begin
                r_max_occ <= w_occ_next;
            end
            if (w_starve && (r_starve_cnt != '1)) begin
                r_starve_cnt <= r_starve_cnt + 32'd1;
            end
        end
    end

    assign bus.max_occ    = r_max_occ;
    assign bus.starve_cnt = r_starve_cnt;
`endif
endmodule

// File: doc/req_ack_fifo.md
Name: req_ack_fifo

Overview:
- Elastic buffer inserted between a stream producer and the `arf` input port. It can equally sit between the `arf` output port and a consumer.
- Upstream side behaves like a consumer: it issues `req` and captures data on an `ack` pulse.
- Downstream side behaves like a producer: it answers `req` with a one-cycle `ack` pulse plus data.
- Purpose: decouple producer stalls from dataflow-graph back-pressure and measure their effect on throughput.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- DEPTH, 4, number of entries; must be a power of two, ≥2.
- ADDR_WIDTH, 2, log2(DEPTH).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- up_req  output  1  registered request to the upstream producer.
- up_ack  input  1  one-cycle pulse from upstream; `up_din` is valid in that cycle.
- up_din  input  DATA_WIDTH  upstream data.
- dn_req  input  1  request level from the downstream consumer.
- dn_ack  output  1  registered one-cycle ack pulse to downstream.
- dn_dout  output  DATA_WIDTH  registered data; valid while `dn_ack`=1 and held afterwards.
- occupancy  output  ADDR_WIDTH+1  current number of stored words, range 0..DEPTH.

Behaviour:
- Reset (`rst`=1 at posedge):
  - `up_req`=0, `dn_ack`=0, `dn_dout`=0, `occupancy`=0.
  - Read and write pointers = 0.
  - Memory contents are don't-care.
  - Reset mid-transfer discards all stored data and any `up_ack` arriving in the same cycle.
- Push: at a posedge with `up_ack`=1, write `up_din` at the write pointer, increment the write pointer modulo DEPTH, and increment `occupancy`.
- Upstream request rule, evaluated each cycle:
  - Next `up_req` = `~up_ack` AND (`occupancy` after this edge's push/pop < DEPTH).
  - Consequence: `up_req` drops for at least one cycle after every `up_ack`, so there is at most one ack per request assertion.
  - `up_req` is never high while full, so a push into a full FIFO cannot occur.
- `up_ack` with `up_req` low in the previous cycle is a protocol violation: the word is ignored and the FIFO is not modified.
- Pop: at a posedge with `dn_req`=1, `dn_ack`=0 and `occupancy`>0:
  - `dn_ack` <= 1 and `dn_dout` <= mem[read pointer].
  - Read pointer increments modulo DEPTH and `occupancy` decrements.
  - In every other case `dn_ack` <= 0 and `dn_dout` holds its value.
- `dn_ack` therefore pulses at most every other cycle, which matches the downstream handshake rule.
- There is no bypass: a word pushed at edge t can be popped at edge t+1 at the earliest, so minimum latency is 1 cycle from `up_ack` to the `dn_ack` edge.
- Simultaneous push and pop in the same edge: both take effect and `occupancy` is unchanged.
  - At `occupancy`=DEPTH a push cannot occur, because `up_req` was low.
  - At `occupancy`=0 the pop is suppressed and the push proceeds.
- Pointers wrap from DEPTH-1 to 0. `occupancy` distinguishes full from empty.
- Data order is strictly FIFO; values are never modified.

Optional Feature:
- Macro: REQ_ACK_FIFO_STATS_EN.
- When defined, two extra output ports are added:
  - max_occ (ADDR_WIDTH+1): high-water mark of `occupancy`, updated on the cycle `occupancy` exceeds it.
  - starve_cnt (32): counts cycles where `dn_req`=1, `dn_ack`=0 and `occupancy`=0; saturates at 2^32-1.
  - Both are cleared by `rst`.
- When not defined, neither port exists and no related logic is built. Core behaviour is identical in both cases.

Test Plan:
- Reset: hold `rst` for 2 cycles with `up_ack` pulsed → `up_req`=0, `dn_ack`=0, `occupancy`=0; the first posedge after reset release drives `up_req`=1.
- Ordered pass-through: ideal producer sending 0,1,2… and consumer always requesting; run 5000 words → consumer receives 0..4999 in order with no gaps or duplicates; `occupancy` never exceeds 1.
- Fill to full: DEPTH=4, `dn_req`=0, producer sends 10,11,12,13 → `occupancy`=4 and `up_req` stays 0; then `dn_req`=1 → `dn_ack` pulses every other cycle delivering 10,11,12,13, and `up_req` reasserts after the first pop.
- Wrap-around: DEPTH=4, push 6 / pop 6 interleaved (values 100..105) → output is 100..105 in order; pointers wrap once.
- Simultaneous push and pop at `occupancy`=2 → `occupancy` stays 2 and the popped value is the oldest entry.
- Stats (macro defined): producer fail_rate 50, consumer always requesting → `starve_cnt`>0 and `max_occ`≤DEPTH; after a `rst` pulse both read 0.
